// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR read/write command scheduler: FSM state
// encodings, transfer direction constants and the default row geometry.
package ddr_pkg;

   localparam int DDR_COL_BITS  = 10;
   localparam int DDR_ROW_BEATS = 2 ** DDR_COL_BITS;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CALC  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef enum logic {
      DIR_WR = 1'b0,
      DIR_RD = 1'b1
   } dir_t;

endpackage

// File: rtl/ddr_burst_splitter.sv
// Combinational burst-length calculator: the next engine burst is the
// smallest of the beats still owed, the engine burst cap and the beats left
// before the current DRAM row ends, so no burst ever straddles a row.
module ddr_burst_splitter #(
   parameter int         COL_BITS  = 10,
   parameter int         LEN_WIDTH = 16,
   parameter logic [7:0] BURST_LEN = 8'd8
) (
   input  logic [COL_BITS-1:0]  col,
   input  logic [LEN_WIDTH-1:0] remaining,
   output logic [7:0]           blen
);

   // Common comparison width wide enough for every operand.
   localparam int W_A = (LEN_WIDTH > COL_BITS + 1) ? LEN_WIDTH : COL_BITS + 1;
   localparam int W   = (W_A > 8) ? W_A : 8;

   logic [COL_BITS:0] room_s;
   logic [W-1:0]      rem_w_s;
   logic [W-1:0]      room_w_s;
   logic [W-1:0]      cap_w_s;

   // Beats left in the row, then pick the smallest of the three limits.
   always_comb begin
      room_s   = {1'b1, {COL_BITS{1'b0}}} - {1'b0, col};
      rem_w_s  = W'(remaining);
      room_w_s = W'(room_s);
      cap_w_s  = W'(BURST_LEN);
      if ((rem_w_s <= cap_w_s) && (rem_w_s <= room_w_s)) begin
         blen = rem_w_s[7:0];
      end else if (room_w_s <= cap_w_s) begin
         blen = room_w_s[7:0];
      end else begin
         blen = BURST_LEN;
      end
   end

endmodule

// File: rtl/ddr_rw_scheduler.sv
// Round-robin write/read command scheduler in front of the AXI burst masters.
// One client command is in flight at a time; it is cut into row-safe bursts,
// each sequenced trig -> done on the selected engine, then completion is
// reported back to the client with a one-cycle done pulse.
module ddr_rw_scheduler
   import ddr_pkg::*;
#(
   parameter int         ADDR_WIDTH = 27,
   parameter int         COL_BITS   = DDR_COL_BITS,
   parameter logic [7:0] BURST_LEN  = 8'd8,
   parameter int         LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init_end,
   input  logic                  wr_cmd_valid,
   output logic                  wr_cmd_ready,
   input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
   input  logic [LEN_WIDTH-1:0]  wr_cmd_beats,
   output logic                  wr_cmd_done,
   input  logic                  rd_cmd_valid,
   output logic                  rd_cmd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,
   input  logic [LEN_WIDTH-1:0]  rd_cmd_beats,
   output logic                  rd_cmd_done,
   output logic                  wr_trig,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [7:0]            wr_len,
   input  logic                  wr_ready,
   input  logic                  wr_done,
   output logic                  rd_trig,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [7:0]            rd_len,
   input  logic                  rd_ready,
   input  logic                  rd_done,
   output logic                  busy
);

   state_t                state_r;
   dir_t                  dir_r;
   dir_t                  last_grant_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [LEN_WIDTH-1:0]  remaining_r;
   logic [7:0]            len_r;

   dir_t                  grant_s;
   logic                  eng_ready_s;
   logic                  eng_done_s;
   logic [7:0]            blen_s;

   ddr_burst_splitter #(
      .COL_BITS  (COL_BITS),
      .LEN_WIDTH (LEN_WIDTH),
      .BURST_LEN (BURST_LEN)
   ) u_splitter (
      .col       (addr_r[COL_BITS-1:0]),
      .remaining (remaining_r),
      .blen      (blen_s)
   );

   // Round-robin pick: a lone requester wins, a tie goes against the last grant.
   always_comb begin
      grant_s = DIR_WR;
      if (wr_cmd_valid && rd_cmd_valid) begin
         grant_s = (last_grant_r == DIR_RD) ? DIR_WR : DIR_RD;
      end else if (rd_cmd_valid) begin
         grant_s = DIR_RD;
      end else begin
         grant_s = DIR_WR;
      end
   end

   // Route the selected engine's handshake inputs; the other engine is ignored.
   always_comb begin
      eng_ready_s = 1'b0;
      eng_done_s  = 1'b0;
      if (dir_r == DIR_WR) begin
         eng_ready_s = wr_ready;
         eng_done_s  = wr_done;
      end else begin
         eng_ready_s = rd_ready;
         eng_done_s  = rd_done;
      end
   end

   // Command FSM with registered client and engine outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         dir_r        <= DIR_WR;
         last_grant_r <= DIR_RD;
         addr_r       <= {ADDR_WIDTH{1'b0}};
         remaining_r  <= {LEN_WIDTH{1'b0}};
         len_r        <= 8'd0;
         wr_cmd_ready <= 1'b0;
         rd_cmd_ready <= 1'b0;
         wr_cmd_done  <= 1'b0;
         rd_cmd_done  <= 1'b0;
         wr_trig      <= 1'b0;
         rd_trig      <= 1'b0;
         wr_addr      <= {ADDR_WIDTH{1'b0}};
         rd_addr      <= {ADDR_WIDTH{1'b0}};
         wr_len       <= 8'd0;
         rd_len       <= 8'd0;
         busy         <= 1'b0;
      end else begin
         wr_cmd_ready <= 1'b0;
         rd_cmd_ready <= 1'b0;
         wr_cmd_done  <= 1'b0;
         rd_cmd_done  <= 1'b0;
         wr_trig      <= 1'b0;
         rd_trig      <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (init_end && (wr_cmd_valid || rd_cmd_valid)) begin
                  if (grant_s == DIR_WR) begin
                     wr_cmd_ready <= 1'b1;
                     addr_r       <= wr_cmd_addr;
                     remaining_r  <= wr_cmd_beats;
                  end else begin
                     rd_cmd_ready <= 1'b1;
                     addr_r       <= rd_cmd_addr;
                     remaining_r  <= rd_cmd_beats;
                  end
                  dir_r        <= grant_s;
                  last_grant_r <= grant_s;
                  state_r      <= ST_CALC;
                  busy         <= 1'b1;
               end
            end
            ST_CALC: begin
               if (remaining_r == {LEN_WIDTH{1'b0}}) begin
                  state_r <= ST_DONE;
               end else begin
                  len_r   <= blen_s;
                  state_r <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (eng_ready_s) begin
                  if (dir_r == DIR_WR) begin
                     wr_trig <= 1'b1;
                     wr_addr <= addr_r;
                     wr_len  <= len_r;
                  end else begin
                     rd_trig <= 1'b1;
                     rd_addr <= addr_r;
                     rd_len  <= len_r;
                  end
                  state_r <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (eng_done_s) begin
                  addr_r      <= addr_r + ADDR_WIDTH'(len_r);
                  remaining_r <= remaining_r - LEN_WIDTH'(len_r);
                  state_r     <= ST_CALC;
               end
            end
            ST_DONE: begin
               if (dir_r == DIR_WR) begin
                  wr_cmd_done <= 1'b1;
               end else begin
                  rd_cmd_done <= 1'b1;
               end
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_rw_scheduler.sv
// Directed testbench for ddr_rw_scheduler with simple engine models that
// log every burst and pulse done three cycles after each trig.
module tb_ddr_rw_scheduler;
   import ddr_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        init_end;
   logic        wr_cmd_valid, wr_cmd_ready, wr_cmd_done;
   logic [26:0] wr_cmd_addr;
   logic [15:0] wr_cmd_beats;
   logic        rd_cmd_valid, rd_cmd_ready, rd_cmd_done;
   logic [26:0] rd_cmd_addr;
   logic [15:0] rd_cmd_beats;
   logic        wr_trig, wr_ready, wr_done;
   logic [26:0] wr_addr;
   logic [7:0]  wr_len;
   logic        rd_trig, rd_ready, rd_done;
   logic [26:0] rd_addr;
   logic [7:0]  rd_len;
   logic        busy;

   typedef struct {
      dir_t        d;
      logic [26:0] a;
      logic [7:0]  l;
      int          c;
   } burst_t;

   burst_t blog[$];
   int     n_checks = 0;
   int     n_errors = 0;
   int     cyc = 0;
   int     acc_cyc;
   int     done_cyc;
   logic   hold_en = 1'b1;

   ddr_rw_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .init_end     (init_end),
      .wr_cmd_valid (wr_cmd_valid),
      .wr_cmd_ready (wr_cmd_ready),
      .wr_cmd_addr  (wr_cmd_addr),
      .wr_cmd_beats (wr_cmd_beats),
      .wr_cmd_done  (wr_cmd_done),
      .rd_cmd_valid (rd_cmd_valid),
      .rd_cmd_ready (rd_cmd_ready),
      .rd_cmd_addr  (rd_cmd_addr),
      .rd_cmd_beats (rd_cmd_beats),
      .rd_cmd_done  (rd_cmd_done),
      .wr_trig      (wr_trig),
      .wr_addr      (wr_addr),
      .wr_len       (wr_len),
      .wr_ready     (wr_ready),
      .wr_done      (wr_done),
      .rd_trig      (rd_trig),
      .rd_addr      (rd_addr),
      .rd_len       (rd_len),
      .rd_ready     (rd_ready),
      .rd_done      (rd_done),
      .busy         (busy)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used for latency measurements
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_burst(input string tag, input int idx, input dir_t d,
                            input logic [26:0] a, input logic [7:0] l);
      if (idx < blog.size()) begin
         chk({tag, "_dir"}, 32'(blog[idx].d), 32'(d));
         chk({tag, "_addr"}, 32'(blog[idx].a), 32'(a));
         chk({tag, "_len"}, 32'(blog[idx].l), 32'(l));
      end else begin
         chk({tag, "_count"}, 32'(blog.size()), 32'(idx + 1));
      end
   endtask

   task automatic send_cmd(input dir_t d, input logic [26:0] a, input logic [15:0] b);
      logic got;
      got = 1'b0;
      if (d == DIR_WR) begin
         wr_cmd_addr = a; wr_cmd_beats = b; wr_cmd_valid = 1'b1;
      end else begin
         rd_cmd_addr = a; rd_cmd_beats = b; rd_cmd_valid = 1'b1;
      end
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if ((d == DIR_WR) ? wr_cmd_ready : rd_cmd_ready) begin
            got = 1'b1;
            acc_cyc = cyc;
            break;
         end
      end
      wr_cmd_valid = 1'b0;
      rd_cmd_valid = 1'b0;
      chk("accept", 32'(got), 32'd1);
   endtask

   task automatic wait_done(input dir_t d);
      logic got;
      got = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         if ((d == DIR_WR) ? wr_cmd_done : rd_cmd_done) begin
            got = 1'b1;
            done_cyc = cyc;
            break;
         end
      end
      chk("cmd_done_seen", 32'(got), 32'd1);
   endtask

   // Write engine model: log burst, check hold of addr/len, pulse done
   initial begin : wr_engine
      burst_t wb;
      wr_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (wr_trig) begin
            wb.d = DIR_WR; wb.a = wr_addr; wb.l = wr_len; wb.c = cyc;
            blog.push_back(wb);
            repeat (2) begin
               @(posedge clk); #1;
               if (hold_en) begin
                  chk("wr_hold_addr", 32'(wr_addr), 32'(wb.a));
                  chk("wr_hold_len", 32'(wr_len), 32'(wb.l));
               end
            end
            wr_done = 1'b1;
            @(posedge clk); #1;
            wr_done = 1'b0;
         end
      end
   end

   // Read engine model: log burst, check hold of addr/len, pulse done
   initial begin : rd_engine
      burst_t rb;
      rd_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rd_trig) begin
            rb.d = DIR_RD; rb.a = rd_addr; rb.l = rd_len; rb.c = cyc;
            blog.push_back(rb);
            repeat (2) begin
               @(posedge clk); #1;
               if (hold_en) begin
                  chk("rd_hold_addr", 32'(rd_addr), 32'(rb.a));
                  chk("rd_hold_len", 32'(rd_len), 32'(rb.l));
               end
            end
            rd_done = 1'b1;
            @(posedge clk); #1;
            rd_done = 1'b0;
         end
      end
   end

   // Safety net against a hung run
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Directed test sequence
   initial begin
      logic [3:0] exp_seq;
      int         ng, nw, nr;
      logic       seen;

      rst_n = 1'b0; init_end = 1'b1;
      wr_cmd_valid = 1'b0; wr_cmd_addr = 27'd0; wr_cmd_beats = 16'd0;
      rd_cmd_valid = 1'b0; rd_cmd_addr = 27'd0; rd_cmd_beats = 16'd0;
      wr_ready = 1'b1; rd_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctl", 32'({wr_cmd_ready, wr_cmd_done, rd_cmd_ready, rd_cmd_done,
                          wr_trig, rd_trig, busy, wr_len, rd_len}), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      rst_n = 1'b1;

      // Both requesters valid from reset: W, R, W, R
      exp_seq = 4'b1010;
      ng = 0; nw = 0; nr = 0;
      wr_cmd_addr = 27'h040; wr_cmd_beats = 16'd4; wr_cmd_valid = 1'b1;
      rd_cmd_addr = 27'h080; rd_cmd_beats = 16'd4; rd_cmd_valid = 1'b1;
      for (int c = 0; c < 300 && ng < 4; c++) begin
         @(posedge clk); #1;
         if (wr_cmd_ready || rd_cmd_ready) begin
            chk("arb_order", 32'({wr_cmd_ready, rd_cmd_ready}),
                exp_seq[ng] ? 32'd1 : 32'd2);
            if (wr_cmd_ready) begin
               nw++;
               if (nw == 2) wr_cmd_valid = 1'b0;
            end
            if (rd_cmd_ready) begin
               nr++;
               if (nr == 2) rd_cmd_valid = 1'b0;
            end
            ng++;
         end
      end
      wr_cmd_valid = 1'b0; rd_cmd_valid = 1'b0;
      chk("arb_grants", 32'(ng), 32'd4);
      wait_done(DIR_RD);
      chk_burst("arb_b0", 0, DIR_WR, 27'h040, 8'd4);
      chk_burst("arb_b1", 1, DIR_RD, 27'h080, 8'd4);
      chk_burst("arb_b2", 2, DIR_WR, 27'h040, 8'd4);
      chk_burst("arb_b3", 3, DIR_RD, 27'h080, 8'd4);
      blog.delete();

      // Write 20 beats from 0 splits into 8, 8, 4
      send_cmd(DIR_WR, 27'h000, 16'd20);
      chk("t1_busy", 32'(busy), 32'd1);
      wait_done(DIR_WR);
      chk("t1_count", 32'(blog.size()), 32'd3);
      chk_burst("t1_b0", 0, DIR_WR, 27'h000, 8'd8);
      chk_burst("t1_b1", 1, DIR_WR, 27'h008, 8'd8);
      chk_burst("t1_b2", 2, DIR_WR, 27'h010, 8'd4);
      if (blog.size() > 0) chk("t1_trig_lat", 32'(blog[0].c - acc_cyc), 32'd2);
      blog.delete();

      // Read across a row boundary: 4 beats then 6 beats
      send_cmd(DIR_RD, 27'h3FC, 16'd10);
      wait_done(DIR_RD);
      chk("t2_count", 32'(blog.size()), 32'd2);
      chk_burst("t2_b0", 0, DIR_RD, 27'h3FC, 8'd4);
      chk_burst("t2_b1", 1, DIR_RD, 27'h400, 8'd6);
      blog.delete();

      // Zero-length command: no burst, done two cycles after accept
      send_cmd(DIR_WR, 27'h123, 16'd0);
      wait_done(DIR_WR);
      chk("t4_done_lat", 32'(done_cyc - acc_cyc), 32'd2);
      chk("t4_no_trig", 32'(blog.size()), 32'd0);
      blog.delete();

      // Read engine not ready: trig held off, then fires once
      rd_ready = 1'b0;
      send_cmd(DIR_RD, 27'h020, 16'd3);
      repeat (5) @(posedge clk);
      #1;
      chk("t5_no_trig", 32'(blog.size()), 32'd0);
      chk("t5_busy", 32'(busy), 32'd1);
      rd_ready = 1'b1;
      wait_done(DIR_RD);
      chk("t5_count", 32'(blog.size()), 32'd1);
      chk_burst("t5_b0", 0, DIR_RD, 27'h020, 8'd3);
      blog.delete();

      // No grant while init_end is low
      init_end = 1'b0;
      wr_cmd_addr = 27'h200; wr_cmd_beats = 16'd2; wr_cmd_valid = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (wr_cmd_ready || busy) seen = 1'b1;
      end
      chk("t6_noinit", 32'(seen), 32'd0);
      init_end = 1'b1;
      send_cmd(DIR_WR, 27'h200, 16'd2);
      wait_done(DIR_WR);
      chk_burst("t6_init_b0", 0, DIR_WR, 27'h200, 8'd2);
      blog.delete();

      // Top-of-space address wraps to zero
      send_cmd(DIR_WR, 27'h7FFFFFC, 16'd8);
      wait_done(DIR_WR);
      chk("t6_wrap_count", 32'(blog.size()), 32'd2);
      chk_burst("t6_wrap_b0", 0, DIR_WR, 27'h7FFFFFC, 8'd4);
      chk_burst("t6_wrap_b1", 1, DIR_WR, 27'h0000000, 8'd4);
      blog.delete();

      // Reset while waiting on the engine: outputs clear, no done pulse
      hold_en = 1'b0;
      send_cmd(DIR_WR, 27'h100, 16'd8);
      repeat (3) @(posedge clk);
      #1;
      chk("t6_rst_pre_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("t6_rst_ctl", 32'({wr_cmd_ready, wr_cmd_done, rd_cmd_ready, rd_cmd_done,
                             wr_trig, rd_trig, busy, wr_len, rd_len}), 32'd0);
      chk("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (wr_cmd_done || busy) seen = 1'b1;
      end
      chk("t6_rst_no_done", 32'(seen), 32'd0);
      chk("t6_rst_trigs", 32'(blog.size()), 32'd1);
      hold_en = 1'b1;
      blog.delete();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
